// File: rtl/prio_enc_arb_if.sv
// Request/grant bundle for prio_enc_arb: request side inputs plus the
// registered valid/ready grant port and round-robin pointer observability.
interface prio_enc_arb_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] req;
    logic         mode_rr;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic [W-1:0] ptr_dbg;

    // Arbiter side
    modport slave (
        input  req, mode_rr, out_ready,
        output out_valid, out_idx, out_onehot, ptr_dbg
    );

    // Requester / consumer side
    modport master (
        output req, mode_rr, out_ready,
        input  out_valid, out_idx, out_onehot, ptr_dbg
    );
endinterface

// File: rtl/prio_enc_arb.sv
// Registered N-way priority encoder / arbiter with runtime-selectable
// fixed-priority or round-robin mode and a valid/ready grant output.
module prio_enc_arb #(
    parameter int N            = 8,
    parameter int RR_RESET_PTR = N - 1
) (
    input  logic           clk,
    input  logic           rst,
    prio_enc_arb_if.slave  bus
);
    localparam int W = $clog2(N);

    logic         valid_q,  valid_d;
    logic [W-1:0] idx_q,    idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic [W-1:0] ptr_q,    ptr_d;

    logic         found;
    logic [W-1:0] win;
    logic         load;

    // Descending search from the start point, wrapping mod N; fixed mode is
    // the same search anchored at N-1.
    always_comb begin
        int unsigned start;
        int unsigned cand;
        logic [W-1:0] cand_w;
        found  = 1'b0;
        win    = '0;
        start  = bus.mode_rr ? int'(ptr_q) : N - 1;
        cand   = 0;
        cand_w = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand   = (start + N - k) % N;
            cand_w = W'(cand);
            if (!found && bus.req[cand_w]) begin
                found = 1'b1;
                win   = cand_w;
            end
        end
    end

    assign load = !valid_q || bus.out_ready;

    always_comb begin
        valid_d  = valid_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        if (load) begin
            if (found) begin
                valid_d       = 1'b1;
                idx_d         = win;
                onehot_d      = '0;
                onehot_d[win] = 1'b1;
                if (bus.mode_rr) begin
                    ptr_d = (win == '0) ? W'(N - 1) : win - W'(1);
                end
            end else begin
                valid_d  = 1'b0;
                onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= W'(RR_RESET_PTR);
        end else begin
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_idx    = idx_q;
    assign bus.out_onehot = onehot_q;
    assign bus.ptr_dbg    = ptr_q;
endmodule
